cache_port_arbiter: RTL

//  Shares the single cache array port (address/data/enable/status) between the load controller
//  (LD) and the store controller (ST) of the data cache. A requester keeps a grant for a whole

---
 rtl/cache_port_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin owner of the shared cache array port with a hold watchdog
module cache_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int EN_W     = 4,
  parameter int STATUS_W = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ld_request_i,
  input  logic                ld_release_i,
  output logic                ld_grant_o,
  input  logic [ADDR_W-1:0]   ld_cache_address_i,
  input  logic [DATA_W-1:0]   ld_cache_data_i,
  input  logic [EN_W-1:0]     ld_cache_read_i,
  input  logic [EN_W-1:0]     ld_cache_write_i,
  input  logic [STATUS_W-1:0] ld_cache_status_i,
  input  logic                st_request_i,
  input  logic                st_release_i,
  output logic                st_grant_o,
  input  logic [ADDR_W-1:0]   st_cache_address_i,
  input  logic [DATA_W-1:0]   st_cache_data_i,
  input  logic [EN_W-1:0]     st_cache_read_i,
  input  logic [EN_W-1:0]     st_cache_write_i,
  input  logic [STATUS_W-1:0] st_cache_status_i,
  output logic [ADDR_W-1:0]   cache_address_o,
  output logic [DATA_W-1:0]   cache_data_o,
  output logic [EN_W-1:0]     cache_read_o,
  output logic [EN_W-1:0]     cache_write_o,
  output logic [STATUS_W-1:0] cache_status_o,
  output logic                busy_o,
  output logic                timeout_o
);
  localparam int CW = $clog2(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, GRANT_LD, GRANT_ST} state_t;
  state_t state, nxt;
  logic last_st;
  logic [CW-1:0] hold;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = (ld_request_i && st_request_i) ? (last_st ? GRANT_LD : GRANT_ST) :
            ld_request_i ? GRANT_LD : st_request_i ? GRANT_ST : IDLE;
    else if (state == GRANT_LD)
      nxt = ld_release_i ? (st_request_i ? GRANT_ST : IDLE) : GRANT_LD;
    else if (state == GRANT_ST)
      nxt = st_release_i ? (ld_request_i ? GRANT_LD : IDLE) : GRANT_ST;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_st   <= 1'b1;
      hold      <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != IDLE && nxt != state) last_st <= (nxt == GRANT_ST);
      hold <= (nxt == IDLE || nxt != state) ? '0 :
              (hold == CW'(MAX_HOLD - 1)) ? hold : hold + 1'b1;
      timeout_o <= nxt != IDLE && nxt == state && hold == CW'(MAX_HOLD - 2);
    end
  end
  assign ld_grant_o      = state == GRANT_LD;
  assign st_grant_o      = state == GRANT_ST;
  assign busy_o          = ld_grant_o | st_grant_o;
  assign cache_address_o = ld_grant_o ? ld_cache_address_i : st_grant_o ? st_cache_address_i : '0;
  assign cache_data_o    = ld_grant_o ? ld_cache_data_i    : st_grant_o ? st_cache_data_i    : '0;
  assign cache_read_o    = ld_grant_o ? ld_cache_read_i    : st_grant_o ? st_cache_read_i    : '0;
  assign cache_write_o   = ld_grant_o ? ld_cache_write_i   : st_grant_o ? st_cache_write_i   : '0;
  assign cache_status_o  = ld_grant_o ? ld_cache_status_i  : st_grant_o ? st_cache_status_i  : '0;
endmodule
